// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, functs, FSM state encoding and ALU codes for the multicycle MIPS controller
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef logic [3:0] state_t;
    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECUTE  = 4'd6;
    localparam state_t S_ALUWB    = 4'd7;
    localparam state_t S_BRANCH   = 4'd8;
    localparam state_t S_ADDIEX   = 4'd9;
    localparam state_t S_ADDIWB   = 4'd10;
    localparam state_t S_JUMP     = 4'd11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_aludec.sv
// rtl/mc_aludec.sv - combinational ALU decoder: (aluop, funct) -> alucontrol
module mc_aludec
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM; optional BNE support via MIPS_MULTICYCLE_BNE_EN
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       irwrite,
    output logic       iord,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state,
    output logic       illegal
);

    localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q;
    logic       wait_state, wait_done, op_known;
    logic       pcwrite, branch, branch_take;
    logic [1:0] aluop;

    // Only the memory-access states stretch; all others are single cycle.
    assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                        (state_q == S_MEMWRITE);
    assign wait_done  = (cnt_q == CNT_LAST);

    always_comb begin
        op_known = 1'b1;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_known = 1'b1;
`ifdef MIPS_MULTICYCLE_BNE_EN
            OP_BNE: op_known = 1'b1;
`endif
            default: op_known = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_MULTICYCLE_BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEX:   state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= 4'd0;
        end else if (wait_state && !wait_done) begin
            cnt_q <= cnt_q + 4'd1;
        end else begin
            state_q <= state_d;
            cnt_q   <= 4'd0;
        end
    end

`ifdef MIPS_MULTICYCLE_BNE_EN
    logic is_bne_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            is_bne_q <= 1'b0;
        end else if (state_q == S_DECODE) begin
            is_bne_q <= (op == OP_BNE);
        end
    end

    assign branch_take = branch & (is_bne_q ? ~zero : zero);
`else
    assign branch_take = branch & zero;
`endif

    always_comb begin
        pcwrite  = 1'b0;
        branch   = 1'b0;
        irwrite  = 1'b0;
        iord     = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = ALUOP_ADD;
        illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = wait_done;
                pcwrite = wait_done;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                illegal = ~op_known;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMREAD:  iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWRITE: begin
                iord     = 1'b1;
                memwrite = wait_done;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB:   regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign pcen  = pcwrite | branch_take;
    assign state = state_q;

    mc_aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule
